// File: rtl/spi_pkg.sv
// Shared SPI link definitions: opcodes, frame lengths and the initiator FSM encoding.
// Imported by the SPI master and by anything else that speaks the same framing.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int CMD_BITS  = 10;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_END
    } spi_state_t;

endpackage

// File: rtl/spi_master.sv
// Host-side SPI initiator: serializes one 10-bit command per request on MOSI under SS_n
// and, for read-data commands, captures the 8-bit reply from MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] SEND_LAST = 4'(CMD_BITS - 1);
    localparam logic [3:0] WAIT_LAST = 4'(RD_TURNAROUND - 1);
    localparam logic [3:0] RECV_LAST = 4'(DATA_BITS - 1);

    spi_state_t r_state;
    spi_state_t w_stateNext;
    logic [3:0] r_cnt;
    logic [9:0] r_tx;
    logic [7:0] r_rx;
    logic       r_isRead;
    logic       r_ssN;
    logic       r_mosi;
    logic       r_rdValid;
    logic [7:0] r_rdData;
    logic       r_rstQ;
    logic       w_accept;
    logic       w_ssNNext;
    logic       w_mosiNext;
    logic       w_rxDone;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    assign w_rxDone = (r_state == ST_RECV) && (w_stateNext == ST_END);

    // Next state plus the values SS_n/MOSI must show once that state is entered,
    // so the registered pins line up with the state they belong to.
    always_comb begin
        w_stateNext = r_state;
        w_mosiNext  = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_stateNext = ST_START;
            ST_START: w_stateNext = ST_SEND;
            ST_SEND:  if (r_cnt == SEND_LAST) w_stateNext = r_isRead ? ST_WAIT : ST_END;
            ST_WAIT:  if (r_cnt == WAIT_LAST) w_stateNext = ST_RECV;
            ST_RECV:  if (r_cnt == RECV_LAST) w_stateNext = ST_END;
            ST_END:   w_stateNext = ST_IDLE;
            default:  w_stateNext = ST_IDLE;
        endcase
        if (w_stateNext == ST_START) begin
            w_mosiNext = cmd[1];
        end else if (w_stateNext == ST_SEND) begin
            w_mosiNext = r_tx[9];
        end
        w_ssNNext = !(w_stateNext inside {ST_START, ST_SEND, ST_WAIT, ST_RECV});
    end

    // A single-cycle reset aborts the frame but keeps the last read byte; only a held
    // reset (asserted on consecutive edges) clears rd_data.
    always_ff @(posedge clk) begin
        r_rstQ <= rst;
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_isRead  <= 1'b0;
            r_ssN     <= 1'b1;
            r_mosi    <= 1'b0;
            r_rdValid <= 1'b0;
            if (r_rstQ) begin
                r_rdData <= '0;
            end
        end else begin
            r_state   <= w_stateNext;
            r_ssN     <= w_ssNNext;
            r_mosi    <= w_mosiNext;
            r_rdValid <= w_rxDone;
            r_cnt     <= (w_stateNext != r_state) ? 4'd0 : r_cnt + 4'd1;
            if (w_accept) begin
                r_tx     <= {cmd, cmd_data};
                r_isRead <= (cmd == CMD_RD_DATA);
            end else if (w_stateNext == ST_SEND) begin
                r_tx <= {r_tx[8:0], 1'b0};
            end
            if (r_state == ST_RECV) begin
                r_rx <= {r_rx[6:0], MISO};
            end
            if (w_rxDone) begin
                r_rdData <= {r_rx[6:0], MISO};
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = !cmd_ready;
    assign SS_n      = r_ssN;
    assign MOSI      = r_mosi;
    assign rd_valid  = r_rdValid;
    assign rd_data   = r_rdData;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a RAM-backed behavioural slave on the default instance,
// and a fixed-reply slave on a second instance built with a longer read turnaround.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] cmd_data;
    logic       cmd_ready, rd_valid, busy, ssN1, mosi1, miso1;
    logic [7:0] rd_data;
    logic       cmdReady2, rdValid2, busy2, ssN2, mosi2, miso2;
    logic [7:0] rdData2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master #(.RD_TURNAROUND(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .SS_n(ssN1), .MOSI(mosi1), .MISO(miso1)
    );

    spi_master #(.RD_TURNAROUND(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmdReady2), .cmd(cmd),
        .cmd_data(cmd_data), .rd_valid(rdValid2), .rd_data(rdData2), .busy(busy2),
        .SS_n(ssN2), .MOSI(mosi2), .MISO(miso2)
    );

    // Slave model for the default instance: frame cycle k is seen at the k-th low negedge.
    logic [7:0] ram [256];
    logic [9:0] sSh1;
    logic [7:0] sAddr1, sRdAddr1, sReply1;
    logic       forceAf = 1'b0;
    int         sCnt1 = 0;
    int         sCnt2 = 0;
    logic [7:0] afByte = 8'hAF;

    always @(negedge clk) begin
        if (ssN1) begin
            sCnt1 = 0;
            miso1 = 1'b0;
        end else begin
            sCnt1++;
            if (sCnt1 >= 2 && sCnt1 <= 11) sSh1 = {sSh1[8:0], mosi1};
            if (sCnt1 == 11) begin
                case (sSh1[9:8])
                    2'b00: sAddr1 = sSh1[7:0];
                    2'b01: ram[sAddr1] = sSh1[7:0];
                    2'b10: sRdAddr1 = sSh1[7:0];
                    default: sReply1 = forceAf ? 8'hAF : ram[sRdAddr1];
                endcase
            end
            miso1 = (sCnt1 >= 13 && sCnt1 <= 20) ? sReply1[20 - sCnt1] : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (ssN2) begin
            sCnt2 = 0;
            miso2 = 1'b0;
        end else begin
            sCnt2++;
            miso2 = (sCnt2 >= 14 && sCnt2 <= 21) ? afByte[21 - sCnt2] : 1'b0;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; offers one command and follows the frame back to IDLE.
    task automatic applyStimulus(input logic [1:0] c, input logic [7:0] d, output int ssLow,
                                 output int rvCycle, output int rvCount, output int readyCycle,
                                 output int busyErr);
        int k;
        ssLow = 0; rvCycle = -1; rvCount = 0; readyCycle = -1; busyErr = 0; k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        cmd = c; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 40 && readyCycle < 0; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (!ssN1) ssLow++;
            if (rd_valid) begin
                rvCount++;
                rvCycle = cyc;
            end
            if (busy !== !cmd_ready) busyErr++;
            if (cmd_ready) readyCycle = cyc;
        end
    endtask

    typedef struct {
        logic [1:0] c;
        logic [7:0] d;
        int         ssLow;
        int         ready;
        int         rv;
        int         rvCyc;
        logic [7:0] rdExp;
    } vec_t;

    vec_t vecs[10];
    logic [1:0] bbCmd[3];
    logic [7:0] bbData[3];

    initial begin
        int ssLow, rvCycle, rvCount, readyCycle, busyErr;
        int rv1Cyc, rv2Cyc, rv1Cnt, rv2Cnt;
        int acc, lowRuns, lowRun, highRun, gaps, gapErr, lowLenErr, notBusy;
        logic prevReady;
        logic [12:0] mosiObs, ssObs;

        vecs[0] = '{2'b00, 8'h7C, 11, 13, 0, -1, 8'h00};
        vecs[1] = '{2'b01, 8'hE9, 11, 13, 0, -1, 8'h00};
        vecs[2] = '{2'b10, 8'h7C, 11, 13, 0, -1, 8'h00};
        vecs[3] = '{2'b11, 8'h00, 20, 22, 1, 21, 8'hE9};
        vecs[4] = '{2'b00, 8'h10, 11, 13, 0, -1, 8'h00};
        vecs[5] = '{2'b01, 8'h5A, 11, 13, 0, -1, 8'h00};
        vecs[6] = '{2'b10, 8'h10, 11, 13, 0, -1, 8'h00};
        vecs[7] = '{2'b11, 8'h3C, 20, 22, 1, 21, 8'h5A};
        vecs[8] = '{2'b10, 8'h7C, 11, 13, 0, -1, 8'h00};
        vecs[9] = '{2'b11, 8'hFF, 20, 22, 1, 21, 8'hE9};
        bbCmd  = '{2'b00, 2'b01, 2'b00};
        bbData = '{8'h33, 8'h44, 8'h55};

        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("reset idle pins", {ssN1, mosi1, cmd_ready, rd_valid, busy, rd_data}, 13'h1400);
        end

        // Write address 0x1C: check the MOSI bit pattern and SS_n window cycle by cycle.
        cmd = 2'b00; cmd_data = 8'h1C; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        mosiObs = '0; ssObs = '0; rvCount = 0;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            if (cyc > 1) @(negedge clk);
            mosiObs = {mosiObs[11:0], mosi1};
            ssObs   = {ssObs[11:0], ssN1};
            if (rd_valid) rvCount++;
        end
        checkOutput("wr 1C mosi bits", mosiObs, 13'h0070);
        checkOutput("wr 1C ss_n bits", ssObs, 13'h0003);
        checkOutput("wr 1C no rd_valid", rvCount, 0);

        // Read data against a fixed 0xAF reply on both turnaround settings.
        forceAf = 1'b1;
        cmd = 2'b11; cmd_data = 8'h00; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rv1Cyc = -1; rv2Cyc = -1; rv1Cnt = 0; rv2Cnt = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (rd_valid) begin rv1Cnt++; rv1Cyc = cyc; end
            if (rdValid2) begin rv2Cnt++; rv2Cyc = cyc; end
        end
        forceAf = 1'b0;
        checkOutput("AF t1 rd_data", rd_data, 8'hAF);
        checkOutput("AF t1 rd_valid cycle", rv1Cyc, 21);
        checkOutput("AF t1 rd_valid count", rv1Cnt, 1);
        checkOutput("AF t2 rd_data", rdData2, 8'hAF);
        checkOutput("AF t2 rd_valid cycle", rv2Cyc, 22);
        checkOutput("AF t2 rd_valid count", rv2Cnt, 1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].c, vecs[i].d, ssLow, rvCycle, rvCount, readyCycle, busyErr);
            checkOutput($sformatf("vec%0d ss_n low cycles", i), ssLow, vecs[i].ssLow);
            checkOutput($sformatf("vec%0d cmd_ready return", i), readyCycle, vecs[i].ready);
            checkOutput($sformatf("vec%0d rd_valid count", i), rvCount, vecs[i].rv);
            checkOutput($sformatf("vec%0d busy vs ready", i), busyErr, 0);
            if (vecs[i].rv != 0) begin
                checkOutput($sformatf("vec%0d rd_valid cycle", i), rvCycle, vecs[i].rvCyc);
                checkOutput($sformatf("vec%0d rd_data", i), rd_data, vecs[i].rdExp);
            end
        end

        // cmd_valid held high across three commands: frames must be separated by two SS_n-high cycles.
        repeat (30) @(negedge clk);
        acc = 0; lowRuns = 0; lowRun = 0; highRun = 0; gaps = 0; gapErr = 0; lowLenErr = 0; notBusy = 0;
        cmd = bbCmd[0]; cmd_data = bbData[0]; cmd_valid = 1'b1;
        prevReady = cmd_ready;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (prevReady && cmd_valid) begin
                acc++;
                if (acc < 3) begin
                    cmd = bbCmd[acc]; cmd_data = bbData[acc];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            prevReady = cmd_ready;
            if (!ssN1) begin
                if (lowRun == 0 && lowRuns > 0) begin
                    gaps++;
                    if (highRun != 2) gapErr++;
                end
                if (lowRun == 0) lowRuns++;
                lowRun++;
                highRun = 0;
                if (cmd_valid && cmd_ready) notBusy++;
            end else begin
                if (lowRun > 0 && lowRun != 11) lowLenErr++;
                lowRun = 0;
                highRun++;
            end
        end
        checkOutput("b2b frame count", lowRuns, 3);
        checkOutput("b2b gap count", gaps, 2);
        checkOutput("b2b gap length errors", gapErr, 0);
        checkOutput("b2b frame length errors", lowLenErr, 0);
        checkOutput("b2b ready while framing", notBusy, 0);
        checkOutput("b2b accepted", acc, 3);

        // One-cycle reset at frame cycle 6 of a read-data frame.
        repeat (30) @(negedge clk);
        cmd = 2'b11; cmd_data = 8'h00; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort ss_n", ssN1, 1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort rd_data kept", rd_data, 8'hE9);
        rvCount = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (rd_valid) rvCount++;
        end
        checkOutput("abort no rd_valid", rvCount, 0);
        applyStimulus(2'b11, 8'h00, ssLow, rvCycle, rvCount, readyCycle, busyErr);
        checkOutput("post abort ss_n low", ssLow, 20);
        checkOutput("post abort rd_valid cycle", rvCycle, 21);
        checkOutput("post abort rd_data", rd_data, 8'hE9);

        // A held reset clears the stored byte.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("held reset rd_data", rd_data, 8'h00);
        checkOutput("held reset ss_n", ssN1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
